// File: rtl/da_spi_pkg.sv
// Shared types, lengths and the fixed AD9788 init table for the DAC SPI scheduler.
package da_spi_pkg;

   localparam int DATA_W   = 40;
   localparam int LEN_W    = 6;
   localparam int INIT_LEN = 9;

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_INIT_ISSUE,
      S_INIT_WAIT,
      S_GAP,
      S_READY,
      S_HOST_ISSUE,
      S_HOST_WAIT
   } state_t;

   localparam logic [LEN_W-1:0] LEN_16 = 6'd16;
   localparam logic [LEN_W-1:0] LEN_24 = 6'd24;
   localparam logic [LEN_W-1:0] LEN_32 = 6'd32;
   localparam logic [LEN_W-1:0] LEN_40 = 6'd40;

   // Entry 0 is the soft reset; 0x89/0x8A are readback instructions.
   localparam logic [DATA_W-1:0] INIT_DATA [INIT_LEN] = '{
      40'h00_0000_0012, 40'h00_0000_0006, 40'h00_0001_0180,
      40'h00_0002_000C, 40'h03_8000_0400, 40'h00_046F_B3FF,
      40'h0A_8000_0000, 40'h00_0089_0000, 40'h8A_0000_0000
   };

   localparam logic [LEN_W-1:0] INIT_BITS [INIT_LEN] = '{
      LEN_16, LEN_16, LEN_24, LEN_24, LEN_40, LEN_32, LEN_40, LEN_24, LEN_40
   };

   function automatic logic len_legal(input logic [LEN_W-1:0] len);
      return (len == LEN_16) || (len == LEN_24) || (len == LEN_32) || (len == LEN_40);
   endfunction

endpackage

// File: rtl/da_spi_sched_if.sv
// Host request and SPI shifter command handshakes; master is the scheduler side.
interface da_spi_sched_if;
   import da_spi_pkg::*;

   logic              host_req_valid;
   logic              host_req_ready;
   logic [DATA_W-1:0] host_req_data;
   logic [LEN_W-1:0]  host_req_len;

   logic              spi_cmd_valid;
   logic              spi_cmd_ready;
   logic [DATA_W-1:0] spi_cmd_data;
   logic [LEN_W-1:0]  spi_cmd_len;
   logic              spi_cmd_done;

   modport master (
      input  host_req_valid, host_req_data, host_req_len, spi_cmd_ready, spi_cmd_done,
      output host_req_ready, spi_cmd_valid, spi_cmd_data, spi_cmd_len
   );

   modport slave (
      output host_req_valid, host_req_data, host_req_len, spi_cmd_ready, spi_cmd_done,
      input  host_req_ready, spi_cmd_valid, spi_cmd_data, spi_cmd_len
   );

endinterface

// File: rtl/da_spi_init_rom.sv
// Combinational init-table lookup; indices past the table return 0 / 16 bits.
module da_spi_init_rom
   import da_spi_pkg::*;
(
   input  logic [3:0]        idx,
   output logic [DATA_W-1:0] data,
   output logic [LEN_W-1:0]  len
);

   always_comb begin
      data = '0;
      len  = LEN_16;
      if (idx < 4'(INIT_LEN)) begin
         data = INIT_DATA[idx];
         len  = INIT_BITS[idx];
      end
   end

endmodule

// File: rtl/da_spi_sched.sv
// Replays the AD9788 init table after clock lock, then arbitrates host writes onto the SPI shifter.
// Host port compiled in only when DA_SPI_HOST_EN is defined.
module da_spi_sched
   import da_spi_pkg::*;
#(
   parameter int GAP_CYCLES = 4,
   parameter int RST_WAIT   = 64,
   parameter int TIMEOUT    = 255
) (
   input  logic           GCLK,
   input  logic           reset_n,
   input  logic           CLM_LOCK,
   input  logic           soft_start,
   da_spi_sched_if.master bus,
   output logic           DA_READY,
   output logic [3:0]     init_idx,
   output logic           busy,
   output logic           err_len,
   output logic           err_timeout
);

   localparam int MAX_A   = (TIMEOUT > RST_WAIT) ? TIMEOUT : RST_WAIT;
   localparam int CNT_MAX = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     gap_last;
   logic [3:0]        rom_idx;
   logic [DATA_W-1:0] rom_data;
   logic [LEN_W-1:0]  rom_len;

   // The next table entry is looked up ahead so ISSUE starts with data already registered.
   assign rom_idx  = (state == S_GAP) ? init_idx + 4'd1 : 4'd0;
   assign gap_last = (!DA_READY && init_idx == 4'd0) ? CW'(RST_WAIT - 1) : CW'(GAP_CYCLES - 1);

   da_spi_init_rom u_rom (
      .idx  (rom_idx),
      .data (rom_data),
      .len  (rom_len)
   );

`ifdef DA_SPI_HOST_EN
   logic host_take;
   assign host_take          = (state == S_READY) && bus.host_req_valid && CLM_LOCK && !soft_start;
   assign bus.host_req_ready = host_take;
   assign err_len            = host_take && !len_legal(bus.host_req_len);
`else
   assign bus.host_req_ready = 1'b0;
   assign err_len            = 1'b0;
`endif

   always_ff @(posedge GCLK or negedge reset_n) begin
      if (!reset_n) begin
         state             <= S_WAIT_LOCK;
         cnt               <= '0;
         init_idx          <= '0;
         DA_READY          <= 1'b0;
         busy              <= 1'b0;
         err_timeout       <= 1'b0;
         bus.spi_cmd_valid <= 1'b0;
         bus.spi_cmd_data  <= '0;
         bus.spi_cmd_len   <= '0;
      end else if (!CLM_LOCK || soft_start) begin
         // Abort from any state; a done arriving afterwards lands in WAIT_LOCK and is ignored.
         state             <= S_WAIT_LOCK;
         cnt               <= '0;
         init_idx          <= '0;
         DA_READY          <= 1'b0;
         busy              <= 1'b0;
         bus.spi_cmd_valid <= 1'b0;
         if (soft_start) begin
            err_timeout <= 1'b0;
         end
      end else begin
         case (state)
            S_WAIT_LOCK: begin
               state             <= S_INIT_ISSUE;
               init_idx          <= '0;
               busy              <= 1'b1;
               bus.spi_cmd_valid <= 1'b1;
               bus.spi_cmd_data  <= rom_data;
               bus.spi_cmd_len   <= rom_len;
            end
            S_INIT_ISSUE, S_HOST_ISSUE: begin
               if (bus.spi_cmd_ready) begin
                  bus.spi_cmd_valid <= 1'b0;
                  cnt               <= '0;
                  state             <= (state == S_INIT_ISSUE) ? S_INIT_WAIT : S_HOST_WAIT;
               end
            end
            S_INIT_WAIT, S_HOST_WAIT: begin
               if (bus.spi_cmd_done) begin
                  state <= S_GAP;
                  cnt   <= '0;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= S_WAIT_LOCK;
                  init_idx    <= '0;
                  DA_READY    <= 1'b0;
                  busy        <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_GAP: begin
               if (cnt == gap_last) begin
                  cnt <= '0;
                  if (DA_READY) begin
                     state <= S_READY;
                     busy  <= 1'b0;
                  end else if (init_idx == 4'(INIT_LEN - 1)) begin
                     init_idx <= init_idx + 4'd1;
                     DA_READY <= 1'b1;
                     state    <= S_READY;
                     busy     <= 1'b0;
                  end else begin
                     init_idx          <= init_idx + 4'd1;
                     state             <= S_INIT_ISSUE;
                     bus.spi_cmd_valid <= 1'b1;
                     bus.spi_cmd_data  <= rom_data;
                     bus.spi_cmd_len   <= rom_len;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_READY: begin
`ifdef DA_SPI_HOST_EN
               if (host_take && len_legal(bus.host_req_len)) begin
                  state             <= S_HOST_ISSUE;
                  busy              <= 1'b1;
                  bus.spi_cmd_valid <= 1'b1;
                  bus.spi_cmd_data  <= bus.host_req_data;
                  bus.spi_cmd_len   <= bus.host_req_len;
               end
`endif
            end
            default: state <= S_WAIT_LOCK;
         endcase
      end
   end

endmodule

// File: tb/tb_da_spi_sched.sv
// Directed bench: init replay, shifter stall, lock loss, host writes, done timeout and soft_start.
// Host expectations follow DA_SPI_HOST_EN.
module tb_da_spi_sched;

   logic       GCLK = 1'b0;
   logic       reset_n;
   logic       CLM_LOCK;
   logic       soft_start;
   logic       DA_READY;
   logic [3:0] init_idx;
   logic       busy;
   logic       err_len;
   logic       err_timeout;

   int vec  = 0;
   int errs = 0;

   localparam logic [39:0] EXP_DATA [9] = '{
      40'h0012, 40'h0006, 40'h010180, 40'h02000C, 40'h0380000400,
      40'h046FB3FF, 40'h0A80000000, 40'h890000, 40'h8A00000000
   };
   localparam logic [5:0] EXP_LEN [9] = '{
      6'd16, 6'd16, 6'd24, 6'd24, 6'd40, 6'd32, 6'd40, 6'd24, 6'd40
   };

   da_spi_sched_if bus ();

   da_spi_sched dut (
      .GCLK        (GCLK),
      .reset_n     (reset_n),
      .CLM_LOCK    (CLM_LOCK),
      .soft_start  (soft_start),
      .bus         (bus.master),
      .DA_READY    (DA_READY),
      .init_idx    (init_idx),
      .busy        (busy),
      .err_len     (err_len),
      .err_timeout (err_timeout)
   );

   always #5 GCLK = ~GCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Acts as the shifter for one command: checks issue spacing and contents, accepts,
   // then either returns done 20 cycles after accept or drops lock mid-wait.
   task automatic serve(input int i, input logic [39:0] d, input logic [5:0] l,
                        input int gap, input int stall, input bit abort);
      int n;
      n = 0;
      while (bus.spi_cmd_valid !== 1'b1 && n < 400) begin
         @(negedge GCLK);
         n++;
      end
      chk($sformatf("gap_before_%0d", i), 64'(n), 64'(gap));
      if (i >= 0) chk($sformatf("idx_%0d", i), 64'(init_idx), 64'(i));
      chk($sformatf("data_%0d", i), 64'(bus.spi_cmd_data), 64'(d));
      chk($sformatf("len_%0d", i), 64'(bus.spi_cmd_len), 64'(l));
      chk($sformatf("busy_%0d", i), 64'(busy), 64'(1));
      for (int k = 0; k < stall; k++) begin
         @(negedge GCLK);
         chk("stall_valid", 64'(bus.spi_cmd_valid), 64'(1));
         chk("stall_data", 64'(bus.spi_cmd_data), 64'(d));
      end
      bus.spi_cmd_ready = 1'b1;
      @(negedge GCLK);
      chk("valid_after_accept", 64'(bus.spi_cmd_valid), 64'(0));
      if (abort) begin
         repeat (4) @(negedge GCLK);
         CLM_LOCK = 1'b0;
         @(negedge GCLK);
         chk("lockloss_valid", 64'(bus.spi_cmd_valid), 64'(0));
         chk("lockloss_ready", 64'(DA_READY), 64'(0));
         chk("lockloss_idx", 64'(init_idx), 64'(0));
         chk("lockloss_busy", 64'(busy), 64'(0));
         bus.spi_cmd_done = 1'b1;
         @(negedge GCLK);
         bus.spi_cmd_done = 1'b0;
         repeat (3) @(negedge GCLK);
         CLM_LOCK = 1'b1;
      end else begin
         repeat (19) @(negedge GCLK);
         bus.spi_cmd_done = 1'b1;
         @(negedge GCLK);
         bus.spi_cmd_done = 1'b0;
      end
   endtask

   initial begin
      int n;
      reset_n            = 1'b0;
      CLM_LOCK           = 1'b0;
      soft_start         = 1'b0;
      bus.host_req_valid = 1'b0;
      bus.host_req_data  = '0;
      bus.host_req_len   = '0;
      bus.spi_cmd_ready  = 1'b1;
      bus.spi_cmd_done   = 1'b0;

      repeat (3) @(negedge GCLK);
      reset_n = 1'b1;
      chk("rst_valid", 64'(bus.spi_cmd_valid), 64'(0));
      chk("rst_data", 64'(bus.spi_cmd_data), 64'(0));
      chk("rst_len", 64'(bus.spi_cmd_len), 64'(0));
      chk("rst_da_ready", 64'(DA_READY), 64'(0));
      chk("rst_idx", 64'(init_idx), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err_timeout", 64'(err_timeout), 64'(0));
      chk("rst_host_ready", 64'(bus.host_req_ready), 64'(0));

      repeat (7) @(negedge GCLK);
      chk("prelock_valid", 64'(bus.spi_cmd_valid), 64'(0));
      CLM_LOCK = 1'b1;

      // First pass aborted by lock loss during the idx 4 wait.
      serve(0, EXP_DATA[0], EXP_LEN[0], 1, 0, 1'b0);
      serve(1, EXP_DATA[1], EXP_LEN[1], 64, 0, 1'b0);
      for (int i = 2; i < 4; i++) serve(i, EXP_DATA[i], EXP_LEN[i], 4, 0, 1'b0);
      serve(4, EXP_DATA[4], EXP_LEN[4], 4, 0, 1'b1);

      // Replay from index 0 with a 30-cycle shifter stall at idx 3.
      serve(0, EXP_DATA[0], EXP_LEN[0], 1, 0, 1'b0);
      serve(1, EXP_DATA[1], EXP_LEN[1], 64, 0, 1'b0);
      serve(2, EXP_DATA[2], EXP_LEN[2], 4, 0, 1'b0);
      chk("replay_da_ready", 64'(DA_READY), 64'(0));
      bus.spi_cmd_ready = 1'b0;
      serve(3, EXP_DATA[3], EXP_LEN[3], 4, 30, 1'b0);
      chk("stall_no_timeout", 64'(err_timeout), 64'(0));
      for (int i = 4; i < 9; i++) serve(i, EXP_DATA[i], EXP_LEN[i], 4, 0, 1'b0);
      repeat (3) @(negedge GCLK);
      chk("da_ready_before_gap_end", 64'(DA_READY), 64'(0));
      @(negedge GCLK);
      chk("da_ready_set", 64'(DA_READY), 64'(1));
      chk("ready_busy", 64'(busy), 64'(0));
      chk("ready_valid", 64'(bus.spi_cmd_valid), 64'(0));

`ifdef DA_SPI_HOST_EN
      bus.host_req_valid = 1'b1;
      bus.host_req_data  = 40'h0501F9;
      bus.host_req_len   = 6'd24;
      #1;
      chk("host_ready", 64'(bus.host_req_ready), 64'(1));
      chk("host_err_len", 64'(err_len), 64'(0));
      @(negedge GCLK);
      bus.host_req_valid = 1'b0;
      serve(-1, 40'h0501F9, 6'd24, 0, 0, 1'b0);
      repeat (3) @(negedge GCLK);
      chk("host_gap_busy", 64'(busy), 64'(1));
      @(negedge GCLK);
      chk("host_done_busy", 64'(busy), 64'(0));
      chk("host_da_ready", 64'(DA_READY), 64'(1));

      bus.host_req_valid = 1'b1;
      bus.host_req_data  = 40'h0A1234;
      bus.host_req_len   = 6'd20;
      #1;
      chk("badlen_ready", 64'(bus.host_req_ready), 64'(1));
      chk("badlen_err", 64'(err_len), 64'(1));
      @(negedge GCLK);
      bus.host_req_valid = 1'b0;
      #1;
      chk("badlen_err_pulse", 64'(err_len), 64'(0));
      repeat (3) @(negedge GCLK);
      chk("badlen_no_cmd", 64'(bus.spi_cmd_valid), 64'(0));
      chk("badlen_busy", 64'(busy), 64'(0));
`else
      bus.host_req_valid = 1'b1;
      bus.host_req_data  = 40'h0501F9;
      bus.host_req_len   = 6'd24;
      #1;
      chk("nohost_ready", 64'(bus.host_req_ready), 64'(0));
      @(negedge GCLK);
      chk("nohost_no_cmd", 64'(bus.spi_cmd_valid), 64'(0));
      bus.host_req_len = 6'd20;
      #1;
      chk("nohost_badlen_ready", 64'(bus.host_req_ready), 64'(0));
      chk("nohost_err_len", 64'(err_len), 64'(0));
      @(negedge GCLK);
      bus.host_req_valid = 1'b0;
`endif

      // soft_start beats a simultaneous host request.
      bus.host_req_valid = 1'b1;
      bus.host_req_data  = 40'h0501F9;
      bus.host_req_len   = 6'd24;
      soft_start         = 1'b1;
      #1;
      chk("soft_host_ready", 64'(bus.host_req_ready), 64'(0));
      @(negedge GCLK);
      soft_start         = 1'b0;
      bus.host_req_valid = 1'b0;
      chk("soft_da_ready", 64'(DA_READY), 64'(0));
      chk("soft_valid", 64'(bus.spi_cmd_valid), 64'(0));

      serve(0, EXP_DATA[0], EXP_LEN[0], 1, 0, 1'b0);
      serve(1, EXP_DATA[1], EXP_LEN[1], 64, 0, 1'b0);

      // idx 2 never gets its done pulse.
      n = 0;
      while (bus.spi_cmd_valid !== 1'b1 && n < 400) begin
         @(negedge GCLK);
         n++;
      end
      chk("tmo_gap", 64'(n), 64'(4));
      chk("tmo_data", 64'(bus.spi_cmd_data), 64'(EXP_DATA[2]));
      n = 0;
      while (err_timeout !== 1'b1 && n < 400) begin
         @(negedge GCLK);
         n++;
      end
      chk("tmo_window", 64'(n >= 255 && n <= 256), 64'(1));
      chk("tmo_idx", 64'(init_idx), 64'(0));
      @(negedge GCLK);
      chk("tmo_replay_valid", 64'(bus.spi_cmd_valid), 64'(1));
      chk("tmo_replay_data", 64'(bus.spi_cmd_data), 64'(EXP_DATA[0]));
      chk("tmo_sticky", 64'(err_timeout), 64'(1));
      soft_start = 1'b1;
      @(negedge GCLK);
      soft_start = 1'b0;
      chk("soft_clears_err", 64'(err_timeout), 64'(0));
      chk("soft_abort_valid", 64'(bus.spi_cmd_valid), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
